usrt_param: RTL and testbench

- Parametrised next-generation USRT core: transmitter, receiver and bit-rate tick generator in one block.
- Adds configurable data width, transmit FIFO, optional parity, overrun/frame error flags and an internal loopback mode.
- Sits between the host data/control pins and the serial line, in the same place as the existing transmitter/receiver pair.
- A single fast system clock plus an internal tick enable replace the separate divided clock.

---
 rtl/usrt_param_if.sv | 30 +++
 rtl/usrt_param.sv | 214 +++++++++++++++++++++
 tb/tb_usrt_param.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/usrt_param_if.sv
// Host-side bundle of the USRT core: transmit FIFO write port, receive
// holding register, serial pins, mode controls and status flags.
interface usrt_param_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_ready;
    logic              so;
    logic              ninto;
    logic              si;
    logic              loopback;
    logic              ien;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_read;
    logic              ninti;
    logic              frame_err;
    logic              overrun;

    modport master (
        output tx_data, tx_load, si, loopback, ien, rx_read,
        input  tx_ready, so, ninto, rx_data, rx_valid, ninti, frame_err, overrun
    );

    modport slave (
        input  tx_data, tx_load, si, loopback, ien, rx_read,
        output tx_ready, so, ninto, rx_data, rx_valid, ninti, frame_err, overrun
    );
endinterface

// File: rtl/usrt_param.sv
// Parametrised USRT core: bit-rate tick generator, transmit FIFO with
// serialiser, and receiver with parity/stop checking and loopback.
module usrt_param #(
    parameter int DATA_W   = 8,
    parameter int DIV      = 10000000,
    parameter int TX_DEPTH = 4,
    parameter int PARITY   = 0
) (
    input  logic         clk,
    input  logic         reset,
    usrt_param_if.slave  bus
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int BIT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    // Parity bit that makes the frame even (PARITY=1) or odd (PARITY=2).
    function automatic logic parity_of(input logic [DATA_W-1:0] d);
        return (^d) ^ (PARITY == 2);
    endfunction

    logic [CNT_W-1:0]  tick_cnt_r;
    logic              tick_s;

    logic [DATA_W-1:0] fifo_mem_r [TX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    count_r;
    logic              push_s;
    logic              pop_s;

    tx_state_t         tx_state_r;
    logic [DATA_W-1:0] tx_shift_r;
    logic [BIT_W-1:0]  tx_bit_r;
    logic              tx_par_r;
    logic              so_r;

    rx_state_t         rx_state_r;
    logic [DATA_W-1:0] rx_shift_r;
    logic [BIT_W-1:0]  rx_bit_r;
    logic              rx_perr_r;
    logic [DATA_W-1:0] rx_data_r;
    logic              rx_valid_r;
    logic              frame_err_r;
    logic              overrun_r;
    logic              line_s;
    logic              complete_s;
    logic              rd_s;

    assign tick_s = (tick_cnt_r == CNT_W'(DIV - 1));

    // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
    assign pop_s  = tick_s && (count_r != '0) &&
                    ((tx_state_r == TX_IDLE) || (tx_state_r == TX_STOP));
    assign push_s = bus.tx_load && ((count_r != (PTR_W+1)'(TX_DEPTH)) || pop_s);

    assign line_s     = bus.loopback ? so_r : bus.si;
    assign complete_s = tick_s && (rx_state_r == RX_STOP);
    assign rd_s       = bus.rx_read && rx_valid_r;

    assign bus.so        = so_r;
    assign bus.tx_ready  = (count_r != (PTR_W+1)'(TX_DEPTH));
    assign bus.ninto     = !(bus.ien && (count_r == '0) && (tx_state_r == TX_IDLE));
    assign bus.ninti     = !(bus.ien && rx_valid_r);
    assign bus.rx_data   = rx_data_r;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.frame_err = frame_err_r;
    assign bus.overrun   = overrun_r;

    // Bit-rate tick counter.
    always_ff @(posedge clk) begin
        if (reset || tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + CNT_W'(1);
        end
    end

    // FIFO storage (contents need no reset, pointers guard validity).
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= bus.tx_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Transmit FSM; STOP chains straight into START when more data waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_r <= TX_IDLE;
            tx_shift_r <= '0;
            tx_bit_r   <= '0;
            tx_par_r   <= 1'b0;
            so_r       <= 1'b1;
        end else if (tick_s) begin
            case (tx_state_r)
                TX_IDLE, TX_STOP: begin
                    if (pop_s) begin
                        tx_shift_r <= fifo_mem_r[rd_ptr_r];
                        tx_par_r   <= parity_of(fifo_mem_r[rd_ptr_r]);
                        so_r       <= 1'b0;
                        tx_state_r <= TX_START;
                    end else begin
                        so_r       <= 1'b1;
                        tx_state_r <= TX_IDLE;
                    end
                end
                TX_START: begin
                    so_r       <= tx_shift_r[0];
                    tx_shift_r <= {1'b0, tx_shift_r[DATA_W-1:1]};
                    tx_bit_r   <= '0;
                    tx_state_r <= TX_DATA;
                end
                TX_DATA: begin
                    if (tx_bit_r == BIT_W'(DATA_W - 1)) begin
                        if (PARITY != 0) begin
                            so_r       <= tx_par_r;
                            tx_state_r <= TX_PARITY;
                        end else begin
                            so_r       <= 1'b1;
                            tx_state_r <= TX_STOP;
                        end
                    end else begin
                        so_r       <= tx_shift_r[0];
                        tx_shift_r <= {1'b0, tx_shift_r[DATA_W-1:1]};
                        tx_bit_r   <= tx_bit_r + BIT_W'(1);
                    end
                end
                TX_PARITY: begin
                    so_r       <= 1'b1;
                    tx_state_r <= TX_STOP;
                end
                default: begin
                    so_r       <= 1'b1;
                    tx_state_r <= TX_IDLE;
                end
            endcase
        end
    end

    // Receive FSM and host-visible holding register with sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_r  <= RX_IDLE;
            rx_shift_r  <= '0;
            rx_bit_r    <= '0;
            rx_perr_r   <= 1'b0;
            rx_data_r   <= '0;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (tick_s) begin
                case (rx_state_r)
                    RX_IDLE: begin
                        if (!line_s) begin
                            rx_bit_r   <= '0;
                            rx_perr_r  <= 1'b0;
                            rx_state_r <= RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        rx_shift_r <= {line_s, rx_shift_r[DATA_W-1:1]};
                        if (rx_bit_r == BIT_W'(DATA_W - 1)) begin
                            rx_state_r <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + BIT_W'(1);
                        end
                    end
                    RX_PARITY: begin
                        rx_perr_r  <= (^rx_shift_r) ^ line_s ^ (PARITY == 2);
                        rx_state_r <= RX_STOP;
                    end
                    default: begin
                        rx_state_r <= RX_IDLE;
                    end
                endcase
            end
            // A read in the completion cycle consumes the old word only.
            rx_valid_r  <= complete_s || (rx_valid_r && !rd_s);
            rx_data_r   <= complete_s ? rx_shift_r : rx_data_r;
            frame_err_r <= (frame_err_r && !rd_s) || (complete_s && (!line_s || rx_perr_r));
            overrun_r   <= (overrun_r && !rd_s) || (complete_s && rx_valid_r && !bus.rx_read);
        end
    end
endmodule

// File: tb/tb_usrt_param.sv
// Directed bench for usrt_param: loopback frames, FIFO full/back-to-back,
// parity and stop errors, overrun, and reset in the middle of a frame.
module tb_usrt_param;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    usrt_param_if #(.DATA_W(8)) bus0 ();
    usrt_param_if #(.DATA_W(8)) bus1 ();

    usrt_param #(.DATA_W(8), .DIV(4), .TX_DEPTH(4), .PARITY(0)) u0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    usrt_param #(.DATA_W(8), .DIV(4), .TX_DEPTH(4), .PARITY(1)) u1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    task automatic idle_inputs();
        bus0.tx_data = 8'h00; bus0.tx_load = 1'b0; bus0.si = 1'b1;
        bus0.loopback = 1'b1; bus0.ien = 1'b1; bus0.rx_read = 1'b0;
        bus1.tx_data = 8'h00; bus1.tx_load = 1'b0; bus1.si = 1'b1;
        bus1.loopback = 1'b0; bus1.ien = 1'b1; bus1.rx_read = 1'b0;
    endtask

    // Leaves the bench at the falling edge just before the first active edge.
    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        tests++; if (bus0.so !== 1'b1) begin fails++; $display("FAIL reset_so: got %b want 1", bus0.so); end
        tests++; if (bus0.tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready: got %b want 1", bus0.tx_ready); end
        tests++; if (bus0.rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", bus0.rx_valid); end
        tests++; if (bus0.ninti !== 1'b1) begin fails++; $display("FAIL reset_ninti: got %b want 1", bus0.ninti); end
        tests++; if (bus0.ninto !== 1'b0) begin fails++; $display("FAIL reset_ninto: got %b want 0", bus0.ninto); end
        tests++; if (bus0.rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h want 00", bus0.rx_data); end
        tests++; if ({bus0.frame_err, bus0.overrun} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b want 00", {bus0.frame_err, bus0.overrun}); end
        bus0.ien = 1'b0;
        #1;
        tests++; if (bus0.ninto !== 1'b1) begin fails++; $display("FAIL reset_ninto_ien0: got %b want 1", bus0.ninto); end
        bus0.ien = 1'b1;
        #1;
    endtask

    task automatic test_single_frame();
        logic [9:0] frame;
        frame = {1'b1, 8'hA5, 1'b0};
        idle_inputs();
        do_reset();
        for (int c = 0; c <= 44; c++) begin
            bus0.tx_load = (c == 0);
            bus0.tx_data = 8'hA5;
            if (c >= 5 && ((c - 5) % 4) == 0 && ((c - 5) / 4) < 10) begin
                tests++;
                if (bus0.so !== frame[(c - 5) / 4]) begin
                    fails++; $display("FAIL frame_so_bit%0d: got %b want %b", (c - 5) / 4, bus0.so, frame[(c - 5) / 4]);
                end
            end
            if (c == 43) begin
                tests++; if (bus0.rx_valid !== 1'b0) begin fails++; $display("FAIL frame_rx_early: got %b want 0", bus0.rx_valid); end
            end
            if (c == 44) begin
                tests++; if (bus0.rx_valid !== 1'b1) begin fails++; $display("FAIL frame_rx_valid: got %b want 1", bus0.rx_valid); end
                tests++; if (bus0.rx_data !== 8'hA5) begin fails++; $display("FAIL frame_rx_data: got %h want a5", bus0.rx_data); end
                tests++; if (bus0.ninti !== 1'b0) begin fails++; $display("FAIL frame_ninti: got %b want 0", bus0.ninti); end
                tests++; if (bus0.ninto !== 1'b0) begin fails++; $display("FAIL frame_ninto: got %b want 0", bus0.ninto); end
                bus0.rx_read = 1'b1;
            end
            @(negedge clk);
        end
        bus0.rx_read = 1'b0;
        tests++; if ({bus0.rx_valid, bus0.ninti} !== 2'b01) begin fails++; $display("FAIL frame_read_clear: got %b want 01", {bus0.rx_valid, bus0.ninti}); end
    endtask

    task automatic test_fifo_full();
        logic [7:0] exp_w [6];
        int got;
        exp_w = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        got = 0;
        idle_inputs();
        do_reset();
        for (int c = 0; c <= 260; c++) begin
            bus0.tx_load = (c <= 5) || (c == 42) || (c == 43);
            bus0.tx_data = (c <= 4) ? 8'(c + 1) : ((c == 43) ? 8'h06 : 8'h0F);
            if (c == 3) begin
                tests++; if (bus0.tx_ready !== 1'b1) begin fails++; $display("FAIL fifo_ready_3: got %b want 1", bus0.tx_ready); end
            end
            if (c == 5 || c == 44) begin
                tests++; if (bus0.tx_ready !== 1'b0) begin fails++; $display("FAIL fifo_full_c%0d: got %b want 0", c, bus0.tx_ready); end
            end
            bus0.rx_read = 1'b0;
            if (bus0.rx_valid === 1'b1) begin
                if (got < 6) begin
                    tests++; if (bus0.rx_data !== exp_w[got]) begin fails++; $display("FAIL fifo_word%0d: got %h want %h", got, bus0.rx_data, exp_w[got]); end
                    tests++; if (c != 44 + 40 * got) begin fails++; $display("FAIL fifo_gap%0d: got cycle %0d want %0d", got, c, 44 + 40 * got); end
                end
                got++;
                bus0.rx_read = 1'b1;
            end
            @(negedge clk);
        end
        bus0.tx_load = 1'b0;
        bus0.rx_read = 1'b0;
        tests++; if (got != 6) begin fails++; $display("FAIL fifo_count: got %0d want 6", got); end
        tests++; if (bus0.overrun !== 1'b0) begin fails++; $display("FAIL fifo_overrun: got %b want 0", bus0.overrun); end
    endtask

    task automatic send_u1(input logic [10:0] bits);
        for (int i = 0; i < 11; i++) begin
            bus1.si = bits[i];
            repeat (4) @(negedge clk);
        end
        bus1.si = 1'b1;
        @(negedge clk);
    endtask

    task automatic read_u1();
        bus1.rx_read = 1'b1;
        @(negedge clk);
        bus1.rx_read = 1'b0;
    endtask

    task automatic test_parity();
        idle_inputs();
        do_reset();
        repeat (4) @(negedge clk);
        send_u1({1'b1, 1'b1, 8'h07, 1'b0});
        tests++; if (bus1.rx_valid !== 1'b1) begin fails++; $display("FAIL par_good_valid: got %b want 1", bus1.rx_valid); end
        tests++; if (bus1.rx_data !== 8'h07) begin fails++; $display("FAIL par_good_data: got %h want 07", bus1.rx_data); end
        tests++; if (bus1.frame_err !== 1'b0) begin fails++; $display("FAIL par_good_ferr: got %b want 0", bus1.frame_err); end
        read_u1();
        send_u1({1'b1, 1'b0, 8'h07, 1'b0});
        tests++; if (bus1.frame_err !== 1'b1) begin fails++; $display("FAIL par_bad_ferr: got %b want 1", bus1.frame_err); end
        tests++; if (bus1.rx_data !== 8'h07) begin fails++; $display("FAIL par_bad_data: got %h want 07", bus1.rx_data); end
        read_u1();
        tests++; if ({bus1.frame_err, bus1.rx_valid} !== 2'b00) begin fails++; $display("FAIL par_read_clear: got %b want 00", {bus1.frame_err, bus1.rx_valid}); end
        send_u1({1'b0, 1'b0, 8'h03, 1'b0});
        tests++; if (bus1.frame_err !== 1'b1) begin fails++; $display("FAIL stop_bad_ferr: got %b want 1", bus1.frame_err); end
        tests++; if (bus1.rx_data !== 8'h03) begin fails++; $display("FAIL stop_bad_data: got %h want 03", bus1.rx_data); end
        read_u1();
        tests++; if ({bus1.frame_err, bus1.overrun} !== 2'b00) begin fails++; $display("FAIL stop_read_clear: got %b want 00", {bus1.frame_err, bus1.overrun}); end
    endtask

    task automatic test_overrun();
        idle_inputs();
        do_reset();
        for (int c = 0; c <= 84; c++) begin
            bus0.tx_load = (c <= 1);
            bus0.tx_data = (c == 0) ? 8'h11 : 8'h22;
            if (c == 83) begin
                tests++; if ({bus0.rx_data, bus0.overrun} !== {8'h11, 1'b0}) begin fails++; $display("FAIL ovr_first: got %h/%b want 11/0", bus0.rx_data, bus0.overrun); end
            end
            if (c == 84) begin
                tests++; if (bus0.overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b want 1", bus0.overrun); end
                tests++; if (bus0.rx_data !== 8'h22) begin fails++; $display("FAIL ovr_newest: got %h want 22", bus0.rx_data); end
            end
            @(negedge clk);
        end
        bus0.tx_load = 1'b0;
        bus0.rx_read = 1'b1;
        @(negedge clk);
        bus0.rx_read = 1'b0;
        tests++; if ({bus0.overrun, bus0.rx_valid} !== 2'b00) begin fails++; $display("FAIL ovr_read_clear: got %b want 00", {bus0.overrun, bus0.rx_valid}); end

        do_reset();
        for (int c = 0; c <= 85; c++) begin
            bus0.tx_load = (c <= 1);
            bus0.tx_data = (c == 0) ? 8'h33 : 8'h44;
            bus0.rx_read = (c == 83);
            if (c == 84) begin
                tests++; if ({bus0.rx_valid, bus0.overrun} !== 2'b10) begin fails++; $display("FAIL ovr_same_cycle: got %b want 10", {bus0.rx_valid, bus0.overrun}); end
                tests++; if (bus0.rx_data !== 8'h44) begin fails++; $display("FAIL ovr_same_data: got %h want 44", bus0.rx_data); end
            end
            if (c == 85) begin
                tests++; if (bus0.rx_valid !== 1'b1) begin fails++; $display("FAIL ovr_still_valid: got %b want 1", bus0.rx_valid); end
            end
            @(negedge clk);
        end
        bus0.tx_load = 1'b0;
        bus0.rx_read = 1'b1;
        @(negedge clk);
        bus0.rx_read = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int bad_so;
        int bad_rx;
        bad_so = 0;
        bad_rx = 0;
        idle_inputs();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            bus0.tx_load = (c <= 1);
            bus0.tx_data = (c == 0) ? 8'h52 : 8'h3C;
            @(negedge clk);
        end
        bus0.tx_load = 1'b0;
        tests++; if ({bus0.so, bus0.ninto} !== 2'b01) begin fails++; $display("FAIL mid_in_frame: got %b want 01", {bus0.so, bus0.ninto}); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++; if (bus0.so !== 1'b1) begin fails++; $display("FAIL mid_so: got %b want 1", bus0.so); end
        tests++; if ({bus0.tx_ready, bus0.ninto} !== 2'b10) begin fails++; $display("FAIL mid_fifo_empty: got %b want 10", {bus0.tx_ready, bus0.ninto}); end
        for (int c = 0; c < 80; c++) begin
            if (bus0.so !== 1'b1) bad_so++;
            if (bus0.rx_valid !== 1'b0) bad_rx++;
            @(negedge clk);
        end
        tests++; if (bad_so != 0) begin fails++; $display("FAIL mid_line_idle: got %0d active cycles want 0", bad_so); end
        tests++; if (bad_rx != 0) begin fails++; $display("FAIL mid_no_rx: got %0d valid cycles want 0", bad_rx); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_fifo_full();
        test_parity();
        test_overrun();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
